// File: rtl/cordic_pkg.sv
// Shared constants and state type for the sequential CORDIC sin/cos engine.
// Angles are Q3.12 radians; vector magnitudes are Q1.14.
package cordic_pkg;

  localparam int unsigned LUT_DEPTH = 16;

  localparam logic signed [15:0] ATAN_LUT [LUT_DEPTH] = '{
    16'sd3217, 16'sd1899, 16'sd1003, 16'sd509, 16'sd256, 16'sd128, 16'sd64, 16'sd32,
    16'sd16,   16'sd8,    16'sd4,    16'sd2,   16'sd1,   16'sd1,   16'sd0,  16'sd0
  };

  // 1/K in Q1.14, so the rotated unit vector comes out with unity gain
  localparam int K_INIT    = 9949;
  localparam int PI_Q      = 12868;
  localparam int HALF_PI_Q = 6434;

  typedef enum logic [1:0] {StIdle, StRot, StDone} state_t;

endpackage

// File: rtl/cordic_stage.sv
// One combinational rotation-mode CORDIC micro-rotation.
// Direction follows the sign of the residual angle z.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic signed [WIDTH-1:0] atan,
  input  logic        [3:0]       shift,
  output logic signed [WIDTH-1:0] x_next,
  output logic signed [WIDTH-1:0] y_next,
  output logic signed [WIDTH-1:0] z_next
);

  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;

  always_comb begin
    x_sh = x >>> shift;
    y_sh = y >>> shift;
    if (!z[WIDTH-1]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_sincos_seq.sv
// Iterative CORDIC sin/cos controller: one micro-rotation per cycle, ITER cycles per angle.
// Define CORDIC_QUAD_FOLD_EN to fold |theta| > pi/2 into range for full [-pi, pi) support.
module cordic_sincos_seq
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] theta,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] sin_o,
  output logic signed [WIDTH-1:0] cos_o,
  output logic                    busy
);

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] x_n, y_n, z_n;
  logic signed [WIDTH-1:0] atan, z_init;
  logic signed [WIDTH-1:0] sin_q, cos_q, sin_d, cos_d;
  logic        [3:0]       i_q;
  logic                    accept, last;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sin_o     = sin_q;
  assign cos_o     = cos_q;

  assign accept = in_valid && (state_q == StIdle);
  assign last   = (i_q == 4'(ITER - 1));
  assign atan   = WIDTH'(ATAN_LUT[i_q]);

  cordic_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .atan   (atan),
    .shift  (i_q),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

`ifdef CORDIC_QUAD_FOLD_EN
  localparam logic signed [WIDTH-1:0] PiW     = WIDTH'(PI_Q);
  localparam logic signed [WIDTH-1:0] HalfPiW = WIDTH'(HALF_PI_Q);

  logic neg_q, neg_init;

  // Rotating by pi negates both components, so fold and flip the sign at the output
  always_comb begin
    neg_init = 1'b0;
    z_init   = theta;
    if (theta > HalfPiW) begin
      z_init   = theta - PiW;
      neg_init = 1'b1;
    end else if (theta < -HalfPiW) begin
      z_init   = theta + PiW;
      neg_init = 1'b1;
    end
  end

  assign sin_d = neg_q ? -y_n : y_n;
  assign cos_d = neg_q ? -x_n : x_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_init;
    end
  end
`else
  assign z_init = theta;
  assign sin_d  = y_n;
  assign cos_d  = x_n;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRot;
      StRot:   if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      i_q   <= '0;
      sin_q <= '0;
      cos_q <= '0;
    end else if (accept) begin
      x_q <= WIDTH'(K_INIT);
      y_q <= '0;
      z_q <= z_init;
      i_q <= '0;
    end else if (state_q == StRot) begin
      x_q <= x_n;
      y_q <= y_n;
      z_q <= z_n;
      i_q <= i_q + 4'd1;
      // Result registers only move on the final rotation; held through DONE and IDLE
      if (last) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
      end
    end
  end

endmodule

// File: doc/cordic_sincos_seq.md
# cordic_sincos_seq

Iterative CORDIC controller that produces sin/cos of one Hough angle per transaction by reusing a single rotation-mode micro-rotation stage over ITER cycles. It owns the angle sequencing: initial gain-compensated vector, per-iteration arctangent table lookup, shift count, optional quadrant folding, and a valid/ready handshake on both sides. It sits between the theta-bin counter of the Hough accumulator and the rho = x·cos + y·sin multiplier.

## Interface
- WIDTH, 16, word width of x/y/z datapath (x,y Q1.14 signed; z/theta Q3.12 signed radians)
- ITER, 12, micro-rotations per transaction, legal 1..14
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  theta request valid
- in_ready  out  1  block can accept theta
- theta  in  WIDTH  angle, Q3.12 signed
- out_valid  out  1  sin_o/cos_o valid
- out_ready  in  1  consumer accepts result
- sin_o  out  WIDTH  sine, Q1.14 signed
- cos_o  out  WIDTH  cosine, Q1.14 signed
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- FSM: IDLE -> ROT -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: x<=K_INIT (9949), y<=0, z<=folded theta, i<=0, neg<=fold flag; go ROT.
- ROT: each cycle one micro-rotation: d = ~z[MSB]; if d: x-=y>>>i, y+=x>>>i, z-=ATAN_LUT[i]; else opposite signs. Shifts are arithmetic (sign-fill). Uses pre-update x/y for both. i increments; after iteration ITER-1 go DONE.
- DONE: out_valid=1; sin_o=neg ? -y : y, cos_o=neg ? -x : x. Hold stable until out_ready; on out_valid&&out_ready go IDLE.
- All add/sub WIDTH-bit two's complement wrap, no saturation (|x|,|y| ≤ 1.65 in Q1.14 never overflows).
- theta outside [-PI_Q, PI_Q-1] is illegal; no checking.
- Simultaneous out_ready in DONE and in_valid: in_ready is 0 in DONE, request waits one cycle (accepted in IDLE).
- in_valid deasserted without acceptance: no state change.

## Timing
- Reset (async assert, sync-released by upstream): state=IDLE, in_ready=1, out_valid=0, busy=0, sin_o=0, cos_o=0, x/y/z/i/neg=0.
- Acceptance at edge T -> out_valid rises at edge T+ITER; latency ITER cycles.
- Minimum initiation interval ITER+2 cycles (accept, ITER rotations, DONE handshake, back in IDLE).
- Reset asserted mid-ROT or in DONE: immediate return to reset values; partial result discarded, no out_valid.
- Outputs registered; no combinational path in->out; in_ready decoded from state register only.

## Configuration
- CORDIC_QUAD_FOLD_EN defined: theta > HALF_PI_Q (6434): z=theta-PI_Q (12868), neg=1; theta < -HALF_PI_Q: z=theta+PI_Q, neg=1; else neg=0. Full [-π, π) supported.
- Undefined: z=theta, neg=0 always; results valid only for |theta| ≤ HALF_PI_Q; fold logic and neg register absent.

## Structure
- Package cordic_pkg: ATAN_LUT[0:15] in Q3.12 (3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 0, 0), K_INIT=9949, PI_Q=12868, HALF_PI_Q=6434, FSM state enum.
- One sub-module: cordic_stage — combinational single micro-rotation (x, y, z, atan, shift i, direction from z sign) -> (x', y', z'); controller instantiates it once and registers its outputs.

## Test plan
- Reset then theta=0 -> after 12 cycles cos_o=16384±8, sin_o=0±8; in_ready low during ROT/DONE.
- theta=2145 (π/6) -> sin_o=8192±8, cos_o=14189±8, out_valid exactly 12 edges after acceptance.
- theta=6434 (π/2) -> sin_o=16384±8, cos_o=0±8; theta=-6434 -> sin_o=-16384±8.
- With CORDIC_QUAD_FOLD_EN, theta=-9651 (-3π/4) -> sin_o=cos_o=-11585±8; theta=12867 -> sin_o≈0±8, cos_o=-16384±8.
- out_ready held low 20 cycles in DONE -> out_valid, sin_o, cos_o stable; in_ready 0; accept resumes one cycle after out_ready.
- rst_n pulsed low at ROT iteration 5 -> all outputs at reset values immediately; next theta=0 transaction yields correct result.
